// File: rtl/bomber_pkg.sv
// Shared constants and geometry helpers for the bomberman playfield blocks.
package bomber_pkg;

  localparam int COORD_W = 10;

  // Bit positions inside bomberman_blocked
  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  // Default sprite sizes, px
  localparam int BOX_W_DEF = 16;
  localparam int BOX_H_DEF = 16;
  localparam int BM_W_DEF  = 16;
  localparam int BM_H_DEF  = 16;

  // Geometry compares run at this width so sums never wrap
  localparam int CMP_W = 16;
  typedef logic [CMP_W-1:0] cmp_t;

  // Box [bx,bx+bw-1]x[by,by+bh-1] against inclusive rect [x0,x1]x[y0,y1].
  // An inverted rect (x1<x0 or y1<y0) hits nothing.
  function automatic logic rect_overlap(input cmp_t bx, input cmp_t by,
                                        input cmp_t bw, input cmp_t bh,
                                        input cmp_t x0, input cmp_t y0,
                                        input cmp_t x1, input cmp_t y1);
    return (x0 <= x1) && (y0 <= y1) &&
           (bx <= x1) && (bx + bw > x0) &&
           (by <= y1) && (by + bh > y0);
  endfunction

endpackage

// File: rtl/box_explode_scan.sv
// Explosion scanner: walks the box table one slot per cycle and emits a
// clear strobe for each alive slot inside the latched blast rectangle.
module box_explode_scan #(
  parameter int NUM_BOXES = 8,
  parameter int IDX_W     = 3,
  parameter int COORD_W   = 10,
  parameter int BOX_W     = 16,
  parameter int BOX_H     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [COORD_W-1:0] exp_x0,
  input  logic [COORD_W-1:0] exp_y0,
  input  logic [COORD_W-1:0] exp_x1,
  input  logic [COORD_W-1:0] exp_y1,
  output logic               exp_done,
  output logic [IDX_W:0]     exp_destroyed,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  input  logic               box_alive,
  input  logic               cfg_collide,
  output logic [IDX_W-1:0]   scan_idx,
  output logic               clr_en
);
  import bomber_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BOXES - 1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     cnt_q, cnt_d, dest_q, dest_d;
  logic [COORD_W-1:0] rx0_q, ry0_q, rx1_q, ry1_q;
  logic [COORD_W-1:0] rx0_d, ry0_d, rx1_d, ry1_d;
  logic               hit;

  assign exp_ready     = (state_q == S_IDLE);
  assign exp_done      = (state_q == S_DONE);
  assign exp_destroyed = dest_q;
  assign scan_idx      = idx_q;

  // Next-state: accept, scan slots, report
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    rx0_d   = rx0_q;
    ry0_d   = ry0_q;
    rx1_d   = rx1_q;
    ry1_d   = ry1_q;
    clr_en  = 1'b0;
    hit     = box_alive && rect_overlap(cmp_t'(box_x), cmp_t'(box_y),
                                        cmp_t'(BOX_W), cmp_t'(BOX_H),
                                        cmp_t'(rx0_q), cmp_t'(ry0_q),
                                        cmp_t'(rx1_q), cmp_t'(ry1_q));
    case (state_q)
      S_IDLE: if (exp_valid) begin
        rx0_d   = exp_x0;
        ry0_d   = exp_y0;
        rx1_d   = exp_x1;
        ry1_d   = exp_y1;
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        clr_en = hit;
        // A config write to the same slot overrides the clear, so it is not a kill
        if (hit && !cfg_collide) cnt_d = cnt_q + 1'b1;
        if (idx_q == LAST) begin
          // Publish the final count together with the done pulse
          dest_d  = cnt_d;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scanner state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      rx0_q   <= '0;
      ry0_q   <= '0;
      rx1_q   <= '0;
      ry1_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      rx0_q   <= rx0_d;
      ry0_q   <= ry0_d;
      rx1_q   <= rx1_d;
      ry1_q   <= ry1_d;
    end
  end

endmodule

// File: rtl/box_field.sv
// Destructible box manager: slot table, pixel hit / sprite addressing,
// bomberman collision flags and explosion-driven destruction.
module box_field #(
  parameter int NUM_BOXES = 8,
  parameter int COORD_W   = bomber_pkg::COORD_W,
  parameter int BOX_W     = bomber_pkg::BOX_W_DEF,
  parameter int BOX_H     = bomber_pkg::BOX_H_DEF,
  parameter int BM_W      = bomber_pkg::BM_W_DEF,
  parameter int BM_H      = bomber_pkg::BM_H_DEF,
  localparam int IDX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1,
  localparam int RW       = $clog2(BOX_H),
  localparam int CW       = $clog2(BOX_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [COORD_W-1:0]   cfg_x,
  input  logic [COORD_W-1:0]   cfg_y,
  input  logic                 cfg_alive,
  input  logic [COORD_W-1:0]   b_x,
  input  logic [COORD_W-1:0]   b_y,
  input  logic [COORD_W-1:0]   v_x,
  input  logic [COORD_W-1:0]   v_y,
  input  logic                 exp_valid,
  output logic                 exp_ready,
  input  logic [COORD_W-1:0]   exp_x0,
  input  logic [COORD_W-1:0]   exp_y0,
  input  logic [COORD_W-1:0]   exp_x1,
  input  logic [COORD_W-1:0]   exp_y1,
  output logic                 exp_done,
  output logic [IDX_W:0]       exp_destroyed,
  output logic                 box_on,
  output logic [RW-1:0]        rom_row,
  output logic [CW-1:0]        rom_col,
  output logic [3:0]           bomberman_blocked,
  output logic [NUM_BOXES-1:0] alive_mask
);
  import bomber_pkg::*;

  localparam int EW = COORD_W + 1;

  logic [NUM_BOXES-1:0][COORD_W-1:0] x_q, y_q;
  logic [NUM_BOXES-1:0]              alive_q;
  logic [NUM_BOXES-1:0]              hit_q, hit_d;
  logic [COORD_W-1:0]                vx_q, vy_q;
  logic                              box_on_q, box_on_d;
  logic [RW-1:0]                     row_q, row_d;
  logic [CW-1:0]                     col_q, col_d;
  logic [3:0]                        blk_q, blk_d;
  logic [IDX_W-1:0]                  scan_idx, sel;
  logic                              clr_en;

  assign alive_mask        = alive_q;
  assign box_on            = box_on_q;
  assign rom_row           = row_q;
  assign rom_col           = col_q;
  assign bomberman_blocked = blk_q;

  box_explode_scan #(
    .NUM_BOXES(NUM_BOXES), .IDX_W(IDX_W), .COORD_W(COORD_W),
    .BOX_W(BOX_W), .BOX_H(BOX_H)
  ) u_scan (
    .clk          (clk),
    .reset        (reset),
    .exp_valid    (exp_valid),
    .exp_ready    (exp_ready),
    .exp_x0       (exp_x0),
    .exp_y0       (exp_y0),
    .exp_x1       (exp_x1),
    .exp_y1       (exp_y1),
    .exp_done     (exp_done),
    .exp_destroyed(exp_destroyed),
    .box_x        (x_q[scan_idx]),
    .box_y        (y_q[scan_idx]),
    .box_alive    (alive_q[scan_idx]),
    .cfg_collide  (cfg_we && (cfg_idx == scan_idx)),
    .scan_idx     (scan_idx),
    .clr_en       (clr_en)
  );

  // Slot table: config write beats a same-cycle scan clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      alive_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BOXES; i++) begin
        if (cfg_we && cfg_idx == IDX_W'(i)) begin
          x_q[i]     <= cfg_x;
          y_q[i]     <= cfg_y;
          alive_q[i] <= cfg_alive;
        end else if (clr_en && scan_idx == IDX_W'(i)) begin
          alive_q[i] <= 1'b0;
        end
      end
    end
  end

  // Per-slot pixel containment and bomberman contact, all in COORD_W+1 bits
  always_comb begin
    hit_d = '0;
    blk_d = '0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      logic [EW-1:0] xe, ye, bx, by, vx, vy;
      logic          vov, hov;
      xe  = {1'b0, x_q[i]};
      ye  = {1'b0, y_q[i]};
      bx  = {1'b0, b_x};
      by  = {1'b0, b_y};
      vx  = {1'b0, v_x};
      vy  = {1'b0, v_y};
      hit_d[i] = alive_q[i] && vx >= xe && vx <= xe + EW'(BOX_W - 1) &&
                 vy >= ye && vy <= ye + EW'(BOX_H - 1);
      vov = by < ye + EW'(BOX_H) && by + EW'(BM_H) > ye;
      hov = bx < xe + EW'(BOX_W) && bx + EW'(BM_W) > xe;
      if (alive_q[i]) begin
        blk_d[DIR_LEFT]  = blk_d[DIR_LEFT]  | (vov && bx > xe && bx <= xe + EW'(BOX_W));
        blk_d[DIR_RIGHT] = blk_d[DIR_RIGHT] | (vov && bx < xe && bx + EW'(BM_W) >= xe);
        blk_d[DIR_UP]    = blk_d[DIR_UP]    | (hov && by > ye && by <= ye + EW'(BOX_H));
        blk_d[DIR_DOWN]  = blk_d[DIR_DOWN]  | (hov && by < ye && by + EW'(BM_H) >= ye);
      end
    end
  end

  // Second pixel stage: lowest-index hit picks the sprite offsets
  always_comb begin
    sel = '0;
    for (int i = NUM_BOXES - 1; i >= 0; i--)
      if (hit_q[i]) sel = IDX_W'(i);
    box_on_d = |hit_q;
    // Only the low bits of the offset are needed, so subtract just those
    row_d = box_on_d ? vy_q[RW-1:0] - y_q[sel][RW-1:0] : '0;
    col_d = box_on_d ? vx_q[CW-1:0] - x_q[sel][CW-1:0] : '0;
  end

  // Pixel pipeline and blocked flags registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      box_on_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      blk_q    <= '0;
    end else begin
      hit_q    <= hit_d;
      vx_q     <= v_x;
      vy_q     <= v_y;
      box_on_q <= box_on_d;
      row_q    <= row_d;
      col_q    <= col_d;
      blk_q    <= blk_d;
    end
  end

endmodule

// File: tb/tb_box_field.sv
// Directed bench for box_field: pixel path, blocked flags, explosion scan.
module tb_box_field;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [9:0] cfg_x = '0, cfg_y = '0;
  logic       cfg_alive = 1'b0;
  logic [9:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;
  logic       exp_valid = 1'b0;
  logic [9:0] exp_x0 = '0, exp_y0 = '0, exp_x1 = '0, exp_y1 = '0;
  logic       exp_ready, exp_done, box_on;
  logic [3:0] exp_destroyed, rom_row, rom_col, bomberman_blocked;
  logic [7:0] alive_mask;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  int dones;

  box_field dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_alive(cfg_alive),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_x0(exp_x0), .exp_y0(exp_y0), .exp_x1(exp_x1), .exp_y1(exp_y1),
    .exp_done(exp_done), .exp_destroyed(exp_destroyed),
    .box_on(box_on), .rom_row(rom_row), .rom_col(rom_col),
    .bomberman_blocked(bomberman_blocked), .alive_mask(alive_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cfg(input logic [2:0] idx, input int x, input int y, input logic al);
    cfg_we = 1'b1; cfg_idx = idx; cfg_x = 10'(x); cfg_y = 10'(y); cfg_alive = al;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic explode(input int x0, input int y0, input int x1, input int y1);
    exp_x0 = 10'(x0); exp_y0 = 10'(y0); exp_x1 = 10'(x1); exp_y1 = 10'(y1);
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
  endtask

  // Ticks until exp_done shows, bounded
  task automatic wait_done(output int c);
    c = 0;
    while (!exp_done && c < 30) begin
      tick();
      c++;
    end
  endtask

  initial begin
    b_x = 10'd500; b_y = 10'd500;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_box_on", box_on, 0);
    chk("rst_blocked", bomberman_blocked, 0);
    chk("rst_alive", alive_mask, 0);
    chk("rst_ready", exp_ready, 1);
    chk("rst_done", exp_done, 0);
    chk("rst_destroyed", exp_destroyed, 0);
    chk("rst_row", rom_row, 0);

    // Single box pixel path
    cfg(3'd0, 160, 50, 1'b1);
    chk("load_alive", alive_mask, 8'h01);
    v_x = 10'd165; v_y = 10'd55;
    tick(); tick();
    chk("pix_on", box_on, 1);
    chk("pix_row", rom_row, 5);
    chk("pix_col", rom_col, 5);
    v_x = 10'd176;
    tick(); tick();
    chk("pix_edge_off", box_on, 0);
    chk("pix_off_col", rom_col, 0);

    // Blocked directions around box (160,50)
    b_x = 10'd176; b_y = 10'd50; tick();
    chk("blk_left", bomberman_blocked, 4'b0001);
    b_x = 10'd144; b_y = 10'd50; tick();
    chk("blk_right", bomberman_blocked, 4'b0010);
    b_x = 10'd160; b_y = 10'd66; tick();
    chk("blk_up", bomberman_blocked, 4'b0100);
    b_x = 10'd160; b_y = 10'd34; tick();
    chk("blk_down", bomberman_blocked, 4'b1000);
    cfg(3'd0, 160, 50, 1'b0);
    tick();
    chk("blk_dead", bomberman_blocked, 4'b0000);

    // Overlapping boxes: lowest index wins
    cfg(3'd1, 200, 100, 1'b1);
    cfg(3'd2, 196, 96, 1'b1);
    v_x = 10'd205; v_y = 10'd105;
    tick(); tick();
    chk("ovl_on", box_on, 1);
    chk("ovl_row1", rom_row, 5);
    chk("ovl_col1", rom_col, 5);
    cfg(3'd1, 200, 100, 1'b0);
    tick(); tick();
    chk("ovl_row2", rom_row, 9);
    chk("ovl_col2", rom_col, 9);
    cfg(3'd2, 196, 96, 1'b0);

    // Explosion with a second offer ignored while busy
    cfg(3'd0, 160, 50, 1'b1);
    cfg(3'd3, 300, 300, 1'b1);
    chk("exp_pre_mask", alive_mask, 8'h09);
    explode(150, 40, 170, 60);
    chk("exp_busy", exp_ready, 0);
    exp_x0 = 10'd290; exp_y0 = 10'd290; exp_x1 = 10'd310; exp_y1 = 10'd310;
    exp_valid = 1'b1;
    tick(); tick(); tick();
    exp_valid = 1'b0;
    wait_done(cyc);
    chk("exp_latency", cyc + 4, N + 1);
    chk("exp_destroyed", exp_destroyed, 1);
    tick();
    chk("exp_done_pulse", exp_done, 0);
    chk("exp_ready_back", exp_ready, 1);
    chk("exp_destroyed_hold", exp_destroyed, 1);
    chk("exp_mask", alive_mask, 8'h08);
    v_x = 10'd165; v_y = 10'd55;
    tick(); tick();
    chk("exp_pix_gone", box_on, 0);

    // Inverted rectangle destroys nothing
    explode(305, 305, 300, 300);
    wait_done(cyc);
    chk("inv_latency", cyc + 1, N + 1);
    chk("inv_destroyed", exp_destroyed, 0);
    chk("inv_mask", alive_mask, 8'h08);

    // Config write to slot 0 in the cycle it is scanned
    cfg(3'd0, 160, 50, 1'b1);
    explode(150, 40, 310, 310);
    cfg(3'd0, 160, 50, 1'b1);
    wait_done(cyc);
    chk("col_destroyed", exp_destroyed, 1);
    tick();
    chk("col_mask", alive_mask, 8'h01);

    // Reset in the middle of a scan
    explode(0, 0, 1023, 1023);
    tick(); tick();
    chk("mid_busy", exp_ready, 0);
    reset = 1'b1;
    #1;
    chk("mid_ready", exp_ready, 1);
    chk("mid_mask", alive_mask, 0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (exp_done) dones++;
    end
    chk("mid_no_done", dones, 0);
    chk("mid_destroyed", exp_destroyed, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
